guess_game_param: RTL and testbench
===================================

Name: guess_game_param

Overview:
- Parametrised number-guessing game controller: a secret is drawn from a free-running LFSR, the player enters guesses, and the block reports over/under/equal on registered LED outputs.
- Adds configurable width and attempt budget, a separate lose condition, narrowing lo/hi hint bounds, a round restart without reset, and a win counter.
- Sits between board switches/buttons (already synchronised upstream) and the LED/7-seg display logic.

Parameters:
- WIDTH, 8, bit width of guess, secret and bounds; legal 4..16.
- MAX_TRIES, 7, guesses allowed per round; legal 1..15.
- LFSR_SEED, 1, LFSR reset value; must be nonzero within WIDTH bits.
- TRIES_W (localparam), $clog2(MAX_TRIES+1), width of tries_left.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- enter  in  1  guess button, level; the block acts on rising edges only
- new_round  in  1  start next round from S_WIN or S_LOSE
- guess  in  WIDTH  player guess
- secret  out  WIDTH  current secret (debug/bench visibility)
- o_over  out  1  last checked guess > secret
- o_under  out  1  last checked guess < secret
- o_equal  out  1  last checked guess == secret
- tries_left  out  TRIES_W  remaining guesses
- lo_bound  out  WIDTH  smallest value still possible
- hi_bound  out  WIDTH  largest value still possible
- win  out  1  high while in S_WIN
- lose  out  1  high while in S_LOSE
- rounds_won  out  8  saturating count of won rounds

Behaviour:
- Reset is asynchronous, active-high, clock is clk. On reset:
  - state = S_SPIN; LFSR = LFSR_SEED; secret = 0.
  - o_over, o_under and o_equal = 0.
  - tries_left = MAX_TRIES; lo_bound = 0; hi_bound = all ones.
  - win = lose = 0; rounds_won = 0; enter_q = 0; guess_q = 0.
- Edge detect: enter_rise = enter & ~enter_q, with enter_q registered every cycle. Holding enter produces exactly one event.
- LFSR: Fibonacci, WIDTH bits, maximal-length taps from the package table (WIDTH 8 uses x^8+x^6+x^5+x^4+1).
  - It advances every cycle in every state, including across rounds; it never reaches 0.
  - The secret is therefore in the range 1..2^WIDTH-1.
- S_SPIN: on enter_rise, secret <= LFSR value and guess_q <= guess, then go to S_CHECK. The first press both draws the secret and submits a guess.
- S_WAIT: on enter_rise, guess_q <= guess, then go to S_CHECK.
- S_CHECK lasts exactly one cycle. At its closing edge:
  - LEDs <= compare(guess_q, secret); tries_left <= tries_left-1.
  - If guess_q > secret: hi_bound <= min(hi_bound, guess_q-1).
  - If guess_q < secret: lo_bound <= max(lo_bound, guess_q+1).
  - Next state: equal goes to S_WIN (rounds_won +1, saturating at 255). Otherwise tries_left==1 goes to S_LOSE. Otherwise go to S_WAIT.
- Latency: enter_rise sampled at edge N; LEDs, tries_left and bounds are valid after edge N+1.
- Out-of-range guesses (outside [lo,hi]) still consume a try. Bounds never widen.
- S_WIN / S_LOSE hold all outputs; enter is ignored.
  - new_round=1 goes to S_SPIN and clears LEDs, win and lose.
  - It restores tries_left = MAX_TRIES and bounds to 0 / all ones.
  - rounds_won and the LFSR are kept.
- new_round is ignored in S_SPIN, S_WAIT and S_CHECK. If new_round and enter_rise occur together in S_WIN/S_LOSE, new_round wins and the edge is discarded.
- A last-try correct guess is a win: the equal check takes precedence over tries exhaustion.
- Reset mid-round aborts immediately to the reset values above.
- Elaboration-time assertions: MAX_TRIES>=1, WIDTH in 4..16, LFSR_SEED nonzero.

Decomposition:
- Package guess_pkg:
  - state enum {S_SPIN, S_WAIT, S_CHECK, S_WIN, S_LOSE}.
  - Function lfsr_taps(width) returning the tap mask for 4..16.
- Sub-module lfsr_gen (WIDTH, SEED): clk, reset, state output; free-running.
- Everything else lives in guess_game_param.

Test Plan:
- Reset, wait 10 cycles, raise enter with guess=secret_from_LFSR_model. Expect o_equal=1 and win=1 two edges later, tries_left=6, rounds_won=1.
- guess=8'hFF then 8'h00 against secret 8'h5A:
  - After the first check: o_over=1, hi_bound=8'hFE.
  - After the second: o_under=1, lo_bound=8'h01, tries_left=5.
- Seven wrong guesses (MAX_TRIES=7): lose=1 after the 7th check and tries_left=0. Then hold enter high for 20 cycles: only one check occurs.
- Exactly one check per press: hold enter high for 20 cycles in S_WAIT and expect exactly one tries_left decrement.
- In S_WIN, pulse new_round and enter on the same cycle:
  - State returns to S_SPIN with tries_left=7, bounds 0/FF and LEDs 0.
  - rounds_won is unchanged and no check occurs.
- Assert reset during S_CHECK: all outputs return to reset values asynchronously. Repeat with WIDTH=4, MAX_TRIES=3 and confirm a lose after 3 misses.

Source files
------------

// File: rtl/guess_game_param_pkg.sv
// Shared types for the guessing-game controller: FSM states and the
// maximal-length LFSR tap table for the supported widths.
package guess_pkg;

    typedef enum logic [2:0] {
        S_SPIN,
        S_WAIT,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    // Bit (n-1) of the mask is set for polynomial term x^n.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/guess_game_param_lfsr.sv
// Free-running Fibonacci LFSR; the shift-left form with XOR feedback never
// leaves the nonzero states once seeded with a nonzero value.
module lfsr_gen
    import guess_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

    logic feedback;
    assign feedback = ^(state & TAPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SEED_V;
        else       state <= {state[WIDTH-2:0], feedback};
    end

endmodule

// File: rtl/guess_game_param.sv
// Number-guessing game controller: draws a secret from the LFSR on the first
// press, compares each guess, narrows lo/hi hints and tracks wins.
module guess_game_param
    import guess_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_TRIES = 7,
    parameter  int LFSR_SEED = 1,
    localparam int TRIES_W   = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enter,
    input  logic               new_round,
    input  logic [WIDTH-1:0]   guess,
    output logic [WIDTH-1:0]   secret,
    output logic               o_over,
    output logic               o_under,
    output logic               o_equal,
    output logic [TRIES_W-1:0] tries_left,
    output logic [WIDTH-1:0]   lo_bound,
    output logic [WIDTH-1:0]   hi_bound,
    output logic               win,
    output logic               lose,
    output logic [7:0]         rounds_won
);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("guess_game_param: WIDTH must be in 4..16");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_tries
        $error("guess_game_param: MAX_TRIES must be in 1..15");
    end
    if ((LFSR_SEED % (1 << WIDTH)) == 0) begin : g_bad_seed
        $error("guess_game_param: LFSR_SEED must be nonzero within WIDTH bits");
    end

    localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);
    localparam logic [TRIES_W-1:0] TRIES_ONE  = TRIES_W'(1);

    state_t           state;
    logic             enter_q;
    logic [WIDTH-1:0] guess_q;
    logic [WIDTH-1:0] lfsr_val;
    logic             enter_rise;

    assign enter_rise = enter & ~enter_q;

    lfsr_gen #(.WIDTH(WIDTH), .SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_SPIN;
            secret     <= '0;
            o_over     <= 1'b0;
            o_under    <= 1'b0;
            o_equal    <= 1'b0;
            tries_left <= TRIES_INIT;
            lo_bound   <= '0;
            hi_bound   <= '1;
            win        <= 1'b0;
            lose       <= 1'b0;
            rounds_won <= 8'd0;
            enter_q    <= 1'b0;
            guess_q    <= '0;
        end else begin
            enter_q <= enter;
            case (state)
                S_SPIN: begin
                    if (enter_rise) begin
                        secret  <= lfsr_val;
                        guess_q <= guess;
                        state   <= S_CHECK;
                    end
                end
                S_WAIT: begin
                    if (enter_rise) begin
                        guess_q <= guess;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    o_over     <= guess_q > secret;
                    o_under    <= guess_q < secret;
                    o_equal    <= guess_q == secret;
                    tries_left <= tries_left - TRIES_ONE;
                    // Bounds only ever tighten: an out-of-range guess leaves them alone.
                    if (guess_q > secret && guess_q <= hi_bound)
                        hi_bound <= guess_q - 1'b1;
                    if (guess_q < secret && guess_q >= lo_bound)
                        lo_bound <= guess_q + 1'b1;
                    if (guess_q == secret) begin
                        state <= S_WIN;
                        win   <= 1'b1;
                        if (rounds_won != 8'hFF) rounds_won <= rounds_won + 8'd1;
                    end else if (tries_left == TRIES_ONE) begin
                        state <= S_LOSE;
                        lose  <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (new_round) begin
                        state      <= S_SPIN;
                        o_over     <= 1'b0;
                        o_under    <= 1'b0;
                        o_equal    <= 1'b0;
                        win        <= 1'b0;
                        lose       <= 1'b0;
                        tries_left <= TRIES_INIT;
                        lo_bound   <= '0;
                        hi_bound   <= '1;
                    end
                end
                default: state <= S_SPIN;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_game_param.sv
// Bench for guess_game_param: an 8-bit/7-try instance checked against a
// round-level model, plus a 4-bit/3-try instance for the small configuration.
module tb_guess_game_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       enter8, new_round8;
    logic [7:0] guess8, secret8, lo8, hi8, rw8;
    logic       over8, under8, equal8, win8, lose8;
    logic [3:0] tries8;

    logic       enter4, new_round4;
    logic [3:0] guess4, secret4, lo4, hi4;
    logic       over4, under4, equal4, win4, lose4;
    logic [1:0] tries4;
    logic [7:0] rw4;

    guess_game_param #(.WIDTH(8), .MAX_TRIES(7), .LFSR_SEED(1)) dut8 (
        .clk(clk), .reset(reset), .enter(enter8), .new_round(new_round8), .guess(guess8),
        .secret(secret8), .o_over(over8), .o_under(under8), .o_equal(equal8),
        .tries_left(tries8), .lo_bound(lo8), .hi_bound(hi8), .win(win8), .lose(lose8),
        .rounds_won(rw8)
    );

    guess_game_param #(.WIDTH(4), .MAX_TRIES(3), .LFSR_SEED(1)) dut4 (
        .clk(clk), .reset(reset), .enter(enter4), .new_round(new_round4), .guess(guess4),
        .secret(secret4), .o_over(over4), .o_under(under4), .o_equal(equal4),
        .tries_left(tries4), .lo_bound(lo4), .hi_bound(hi4), .win(win4), .lose(lose4),
        .rounds_won(rw4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Clock edges seen since reset released; the LFSR has stepped this many times.
    int edge_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // LFSR value after n steps from seed 1, using the polynomial terms directly.
    function automatic int lfsr_model(input int n, input int w);
        int v, fb, steps;
        v = 1;
        steps = n % ((1 << w) - 1);
        for (int i = 0; i < steps; i++) begin
            if (w == 8) fb = v[7] ^ v[5] ^ v[4] ^ v[3];
            else        fb = v[3] ^ v[2];
            v = ((v << 1) | fb) & ((1 << w) - 1);
        end
        return v;
    endfunction

    // Round-level model of the 8-bit instance. phase: 0 spin, 1 playing, 2 won, 3 lost.
    int       m_phase, m_secret, m_tries, m_lo, m_hi, m_wins;
    logic [2:0] m_leds;

    task automatic model_reset();
        m_phase = 0; m_secret = 0; m_tries = 7; m_lo = 0; m_hi = 255; m_wins = 0; m_leds = 3'b000;
    endtask

    task automatic model_new_round();
        if (m_phase >= 2) begin
            m_phase = 0; m_tries = 7; m_lo = 0; m_hi = 255; m_leds = 3'b000;
        end
    endtask

    task automatic model_press(input int g, input int cnt);
        if (m_phase >= 2) return;
        if (m_phase == 0) m_secret = lfsr_model(cnt, 8);
        m_leds  = {g > m_secret, g < m_secret, g == m_secret};
        m_tries = m_tries - 1;
        if (g > m_secret && g - 1 < m_hi) m_hi = g - 1;
        if (g < m_secret && g + 1 > m_lo) m_lo = g + 1;
        if (g == m_secret) begin
            m_phase = 2;
            if (m_wins < 255) m_wins = m_wins + 1;
        end else if (m_tries == 0) begin
            m_phase = 3;
        end else begin
            m_phase = 1;
        end
    endtask

    // Called just after a falling edge; returns after the check result is visible.
    task automatic press8(input int g);
        model_press(g, edge_cnt);
        guess8 = g[7:0];
        enter8 = 1'b1;
        @(negedge clk);
        enter8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_new_round8();
        new_round8 = 1'b1;
        @(negedge clk);
        new_round8 = 1'b0;
        model_new_round();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [40:0] dut8_vec();
        return {secret8, over8, under8, equal8, tries8, lo8, hi8, win8, lose8, rw8};
    endfunction

    function automatic logic [40:0] model_vec();
        return {m_secret[7:0], m_leds, m_tries[3:0], m_lo[7:0], m_hi[7:0],
                m_phase == 2, m_phase == 3, m_wins[7:0]};
    endfunction

    task automatic test_reset();
        logic [40:0] got;
        logic [40:0] exp8;
        logic [25:0] got4;
        reset = 1'b1;
        enter8 = 0; new_round8 = 0; guess8 = 0;
        enter4 = 0; new_round4 = 0; guess4 = 0;
        repeat (3) @(negedge clk);
        exp8 = {8'h00, 3'b000, 4'd7, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00};
        got = dut8_vec();
        n_checks++; if (got !== exp8) $display("FAIL reset_dut8: got %h want %h", got, exp8); else n_pass++;
        got4 = {secret4, over4, under4, equal4, tries4, lo4, hi4, win4, lose4, rw4};
        n_checks++; if (got4 !== {4'h0, 3'b000, 2'd3, 4'h0, 4'hF, 2'b00, 8'h00})
            $display("FAIL reset_dut4: got %h want %h", got4, {4'h0, 3'b000, 2'd3, 4'h0, 4'hF, 2'b00, 8'h00});
        else n_pass++;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        got = dut8_vec();
        n_checks++; if (got !== model_vec()) $display("FAIL idle_after_reset: got %h want %h", got, model_vec()); else n_pass++;
    endtask

    task automatic test_first_win();
        int g;
        repeat (10) @(negedge clk);
        g = lfsr_model(edge_cnt, 8);
        press8(g);
        n_checks++; if ({over8, under8, equal8} !== 3'b001) $display("FAIL first_win_leds: got %b want 001", {over8, under8, equal8}); else n_pass++;
        n_checks++; if (win8 !== 1'b1) $display("FAIL first_win_flag: got %b want 1", win8); else n_pass++;
        n_checks++; if (tries8 !== 4'd6) $display("FAIL first_win_tries: got %0d want 6", tries8); else n_pass++;
        n_checks++; if (rw8 !== 8'd1) $display("FAIL first_win_rounds: got %0d want 1", rw8); else n_pass++;
        n_checks++; if (secret8 !== g[7:0]) $display("FAIL first_win_secret: got %h want %h", secret8, g[7:0]); else n_pass++;
    endtask

    task automatic test_new_round_collision();
        logic [40:0] got;
        new_round8 = 1'b1;
        enter8 = 1'b1;
        guess8 = 8'($urandom_range(0, 255));
        @(negedge clk);
        new_round8 = 1'b0;
        model_new_round();
        repeat (3) @(negedge clk);
        enter8 = 1'b0;
        repeat (2) @(negedge clk);
        got = dut8_vec();
        n_checks++; if (got !== model_vec()) $display("FAIL collision_state: got %h want %h", got, model_vec()); else n_pass++;
        n_checks++; if (rw8 !== 8'd1) $display("FAIL collision_rounds: got %0d want 1", rw8); else n_pass++;
    endtask

    task automatic test_over_under();
        while (lfsr_model(edge_cnt, 8) == 255) @(negedge clk);
        press8(255);
        n_checks++; if ({over8, under8, equal8} !== 3'b100) $display("FAIL over_leds: got %b want 100", {over8, under8, equal8}); else n_pass++;
        n_checks++; if (hi8 !== 8'hFE) $display("FAIL over_hi: got %h want fe", hi8); else n_pass++;
        press8(0);
        n_checks++; if ({over8, under8, equal8} !== 3'b010) $display("FAIL under_leds: got %b want 010", {over8, under8, equal8}); else n_pass++;
        n_checks++; if (lo8 !== 8'h01) $display("FAIL under_lo: got %h want 01", lo8); else n_pass++;
        n_checks++; if (tries8 !== 4'd5) $display("FAIL under_tries: got %0d want 5", tries8); else n_pass++;
    endtask

    task automatic test_hold_in_wait();
        logic [40:0] got;
        model_press(0, edge_cnt);
        guess8 = 8'h00;
        enter8 = 1'b1;
        repeat (20) @(negedge clk);
        enter8 = 1'b0;
        @(negedge clk);
        n_checks++; if (tries8 !== 4'd4) $display("FAIL hold_wait_tries: got %0d want 4", tries8); else n_pass++;
        got = dut8_vec();
        n_checks++; if (got !== model_vec()) $display("FAIL hold_wait_state: got %h want %h", got, model_vec()); else n_pass++;
    endtask

    task automatic test_lose_and_hold();
        logic [40:0] got;
        int g;
        for (int i = 0; i < 4; i++) begin
            g = $urandom_range(0, 255);
            if (g == m_secret) g = g ^ 1;
            press8(g);
        end
        n_checks++; if (lose8 !== 1'b1) $display("FAIL lose_flag: got %b want 1", lose8); else n_pass++;
        n_checks++; if (tries8 !== 4'd0) $display("FAIL lose_tries: got %0d want 0", tries8); else n_pass++;
        got = dut8_vec();
        guess8 = m_secret[7:0];
        enter8 = 1'b1;
        repeat (20) @(negedge clk);
        enter8 = 1'b0;
        @(negedge clk);
        n_checks++; if (dut8_vec() !== got) $display("FAIL lose_hold: got %h want %h", dut8_vec(), got); else n_pass++;
        n_checks++; if (got !== model_vec()) $display("FAIL lose_state: got %h want %h", got, model_vec()); else n_pass++;
        pulse_new_round8();
    endtask

    task automatic test_random_rounds();
        logic [40:0] got;
        int g, k;
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            k = 0;
            while (m_phase < 2 && k < 10) begin
                if (m_phase == 0 || $urandom_range(0, 4) == 0) g = $urandom_range(0, 255);
                else g = $urandom_range(m_lo, m_hi);
                press8(g);
                got = dut8_vec();
                n_checks++; if (got !== model_vec()) $display("FAIL random_check r%0d: got %h want %h", r, got, model_vec()); else n_pass++;
                k++;
            end
            pulse_new_round8();
            got = dut8_vec();
            n_checks++; if (got !== model_vec()) $display("FAIL random_restart r%0d: got %h want %h", r, got, model_vec()); else n_pass++;
        end
    endtask

    task automatic test_reset_in_check();
        logic [40:0] got;
        logic [40:0] exp8;
        guess8 = 8'($urandom_range(0, 255));
        enter8 = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        exp8 = {8'h00, 3'b000, 4'd7, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00};
        got = dut8_vec();
        n_checks++; if (got !== exp8) $display("FAIL reset_in_check: got %h want %h", got, exp8); else n_pass++;
        @(negedge clk);
        enter8 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (dut8_vec() !== model_vec()) $display("FAIL after_reset_in_check: got %h want %h", dut8_vec(), model_vec()); else n_pass++;
    endtask

    task automatic test_small_config();
        int s, g, lo, hi;
        repeat ($urandom_range(1, 9)) @(negedge clk);
        s = lfsr_model(edge_cnt, 4);
        lo = 0; hi = 15;
        for (int i = 0; i < 3; i++) begin
            g = $urandom_range(0, 15);
            if (g == s) g = g ^ 1;
            if (g > s && g - 1 < hi) hi = g - 1;
            if (g < s && g + 1 > lo) lo = g + 1;
            guess4 = g[3:0];
            enter4 = 1'b1;
            @(negedge clk);
            enter4 = 1'b0;
            @(negedge clk);
            n_checks++; if ({over4, under4, equal4} !== {g > s, g < s, 1'b0})
                $display("FAIL small_leds%0d: got %b want %b", i, {over4, under4, equal4}, {g > s, g < s, 1'b0});
            else n_pass++;
            n_checks++; if ({tries4, lo4, hi4} !== {2'(2 - i), lo[3:0], hi[3:0]})
                $display("FAIL small_tries_bounds%0d: got %h want %h", i, {tries4, lo4, hi4}, {2'(2 - i), lo[3:0], hi[3:0]});
            else n_pass++;
        end
        n_checks++; if ({win4, lose4, secret4} !== {1'b0, 1'b1, s[3:0]})
            $display("FAIL small_lose: got %h want %h", {win4, lose4, secret4}, {1'b0, 1'b1, s[3:0]});
        else n_pass++;
    endtask

    task automatic test_win_saturation();
        do_reset();
        for (int r = 0; r < 258; r++) begin
            press8(lfsr_model(edge_cnt, 8));
            n_checks++; if (dut8_vec() !== model_vec()) $display("FAIL sat_round%0d: got %h want %h", r, dut8_vec(), model_vec()); else n_pass++;
            pulse_new_round8();
        end
        n_checks++; if (rw8 !== 8'd255) $display("FAIL sat_rounds_won: got %0d want 255", rw8); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_win();
        test_new_round_collision();
        test_over_under();
        test_hold_in_wait();
        test_lose_and_hold();
        test_random_rounds();
        test_reset_in_check();
        test_small_config();
        test_win_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
